stoch_signed_decode: RTL and testbench
======================================

// Module: stoch_signed_decode
// PURPOSE
//   Converts NUM_ELEMS signed stochastic bitstream pairs (x_p/x_m) back to binary two's-complement values.
//   Each lane counts x_p ones minus x_m ones over a fixed window of 2^WINDOW_LOG2 cycles.
//   Sits at the output end of a stochastic layer chain (e.g. after signed maxpool).
//   Hands decoded vectors to the binary domain via a valid/ready handshake.
// PARAMETERS
//   NUM_ELEMS    16  number of parallel signed stream pairs (lanes)
//   WINDOW_LOG2  8   log2 of the accumulation window length in cycles
//   OUT_WIDTH    WINDOW_LOG2+2  signed output width per lane; localparam, not overridable
// PORTS
//   CLK      in   1                    clock, rising edge
//   nRST     in   1                    asynchronous active-low reset
//   start    in   1                    request a new decode window
//   x_p      in   NUM_ELEMS            positive-part bitstreams, bit i = lane i
//   x_m      in   NUM_ELEMS            negative-part bitstreams, bit i = lane i
//   busy     out  1                    high while in ACCUM
//   y        out  NUM_ELEMS*OUT_WIDTH  lane i at y[i*OUT_WIDTH +: OUT_WIDTH], signed
//   y_valid  out  1                    y holds a completed result
//   y_ready  in   1                    consumer accepts y when y_valid & y_ready
// BEHAVIOUR
// - Reset (async, nRST=0): state=IDLE, all lane counters=0, window counter=0, y=0, y_valid=0, busy=0.
// - States: IDLE, ACCUM, HOLD.
// - IDLE: start=1 -> ACCUM next cycle; lane counters and window counter cleared. Streams ignored in IDLE.
// - ACCUM: every cycle, per lane, cnt += x_p[i] - x_m[i] (x_p=x_m=1 nets 0).
//   The window counter counts samples; exactly 2^WINDOW_LOG2 samples are taken.
//   The first sample is taken on the first ACCUM cycle, i.e. the cycle after start.
//   start is ignored in ACCUM.
// - End of window: on the cycle after the last sample, y is loaded with the final counts, y_valid=1, state=HOLD.
//   Latency from start high to y_valid high = 2^WINDOW_LOG2 + 1 cycles.
// - Arithmetic: each lane counter is signed OUT_WIDTH bits, range [-2^W, +2^W], with W=WINDOW_LOG2. No saturation is needed.
//   y is NOT normalised; the consumer interprets it as value * 2^W.
// - HOLD: y and y_valid are stable until handshake (y_valid & y_ready).
//   - Handshake without start: y_valid=0 next cycle, state -> IDLE; y keeps its last value.
//   - Handshake with start in the same cycle: state -> ACCUM directly, counters cleared, y_valid=0.
//   - start without y_ready: ignored; stays in HOLD. There is no overwrite of an unconsumed result.
// - busy = (state==ACCUM); it is registered and decoded from the state.
// - Reset mid-window or mid-HOLD: immediate return to reset values; the partial result is discarded.
// - Window counter wraps to 0 exactly at window end; it never overflows into the next window.
// STRUCTURE
// - Package stoch_decode_pkg:
//   - state enum {IDLE, ACCUM, HOLD}
//   - function out_width(window_log2) = window_log2+2
// - Sub-module stoch_signed_counter (per lane; params WIDTH):
//   - inputs CLK, nRST, clr, en, x_p, x_m
//   - signed up/down count output
//   - instantiated NUM_ELEMS times via generate
// - Top level holds the FSM, the window counter and the output registers.
// TESTING (NUM_ELEMS=4, WINDOW_LOG2=4 unless noted; window = 16)
// 1. Lane0 x_p=1, x_m=0 for all 16 samples; others 0 -> y lane0=+16, lanes1-3=0; y_valid high 17 cycles after start.
// 2. Lane1 x_m=1 for 16 samples -> lane1=-16 (6'b110000). Lane2 x_p=x_m=1 -> 0. Lane3 x_p alternating 1/0 -> +8.
// 3. y_ready held low 10 cycles after y_valid, with start pulsed during the hold -> y stable, y_valid stays 1, no new window.
//    Then y_ready=1 -> y_valid drops next cycle, state IDLE.
// 4. y_ready=1 and start=1 in the same HOLD cycle -> busy=1 next cycle; second result valid 17 cycles later.
//    Use a known pattern: lane0 x_p 4 of 16 -> +4.
// 5. nRST pulsed low at sample 9 of a window -> all outputs 0 asynchronously. After release, state IDLE and y_valid stays 0 with no start.
// 6. Randomised streams, WINDOW_LOG2=8, NUM_ELEMS=16, 100 windows with random y_ready stalls -> each lane equals the scoreboard count(p)-count(m).

Source files
------------

// File: rtl/stoch_decode_pkg.sv
// Shared types and helpers for the signed stochastic-to-binary decoder.
package stoch_decode_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int out_width(input int window_log2);
    return window_log2 + 2;
  endfunction

  // Net contribution of one signed sample pair: +1, 0 or -1.
  function automatic logic signed [1:0] step(input logic p, input logic m);
    return $signed({1'b0, p}) - $signed({1'b0, m});
  endfunction

endpackage

// File: rtl/stoch_signed_counter.sv
// Per-lane signed up/down counter: adds x_p - x_m each enabled cycle.
module stoch_signed_counter
  import stoch_decode_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    x_p,
  input  logic                    x_m,
  output logic signed [WIDTH-1:0] cnt
);

  // NOTE: every flop in this block set is cleared by the async reset so a
  // partially accumulated window can never leak into the next one.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WIDTH'(step(x_p, x_m));
    end
  end

endmodule

// File: rtl/stoch_signed_decode.sv
// Decodes NUM_ELEMS signed stochastic stream pairs into two's-complement counts
// over a 2^WINDOW_LOG2-cycle window and hands them off with valid/ready.
module stoch_signed_decode
  import stoch_decode_pkg::*;
#(
  parameter int NUM_ELEMS   = 16,
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                                          CLK,
  input  logic                                          nRST,
  input  logic                                          start,
  input  logic [NUM_ELEMS-1:0]                          x_p,
  input  logic [NUM_ELEMS-1:0]                          x_m,
  output logic                                          busy,
  output logic [NUM_ELEMS*out_width(WINDOW_LOG2)-1:0]   y,
  output logic                                          y_valid,
  input  logic                                          y_ready
);

  localparam int OUT_WIDTH = out_width(WINDOW_LOG2);

  state_t                       state, state_nxt;
  logic [WINDOW_LOG2-1:0]       win_cnt;
  logic                         last_sample, handshake, launch, accum;
  logic signed [OUT_WIDTH-1:0]  lane_cnt [NUM_ELEMS];
  logic signed [OUT_WIDTH-1:0]  lane_fin [NUM_ELEMS];

  assign accum       = (state == ACCUM);
  assign last_sample = accum && (win_cnt == '1);
  assign handshake   = (state == HOLD) && y_valid && y_ready;
  assign launch      = ((state == IDLE) && start) || (handshake && start);

  // NOTE: next-state logic assigns a default first so no path leaves
  // state_nxt unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (last_sample) state_nxt = HOLD;
      HOLD:    if (handshake) state_nxt = start ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_ELEMS; i++) begin : g_lane
    stoch_signed_counter #(.WIDTH(OUT_WIDTH)) u_cnt (
      .CLK  (CLK),
      .nRST (nRST),
      .clr  (launch),
      .en   (accum),
      .x_p  (x_p[i]),
      .x_m  (x_m[i]),
      .cnt  (lane_cnt[i])
    );
    // The result register captures the count including the final sample.
    assign lane_fin[i] = lane_cnt[i] + OUT_WIDTH'(step(x_p[i], x_m[i]));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      win_cnt <= '0;
      busy    <= 1'b0;
      y_valid <= 1'b0;
      y       <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ACCUM);
      if (launch) begin
        win_cnt <= '0;
      end else if (accum) begin
        win_cnt <= win_cnt + WINDOW_LOG2'(1);
      end
      if (last_sample) begin
        y_valid <= 1'b1;
        for (int i = 0; i < NUM_ELEMS; i++) begin
          y[i*OUT_WIDTH +: OUT_WIDTH] <= lane_fin[i];
        end
      end else if (handshake) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stoch_signed_decode.sv
// Bench: directed scenarios on a small instance, randomized windows on a full-size one.
module tb_stoch_signed_decode;

  localparam int NA = 4,  WA = 4, OA = WA + 2, LA = 1 << WA;
  localparam int NB = 16, WB = 8, OB = WB + 2, LB = 1 << WB;

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  logic              start_a = 1'b0, y_ready_a = 1'b0, busy_a, y_valid_a;
  logic [NA-1:0]     xp_a = '0, xm_a = '0;
  logic [NA*OA-1:0]  y_a;

  logic              start_b = 1'b0, y_ready_b = 1'b0, busy_b, y_valid_b;
  logic [NB-1:0]     xp_b = '0, xm_b = '0;
  logic [NB*OB-1:0]  y_b;

  logic [NA-1:0]     pp [LA];
  logic [NA-1:0]     pm [LA];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  stoch_signed_decode #(.NUM_ELEMS(NA), .WINDOW_LOG2(WA)) dut_a (
    .CLK(clk), .nRST(n_rst), .start(start_a), .x_p(xp_a), .x_m(xm_a),
    .busy(busy_a), .y(y_a), .y_valid(y_valid_a), .y_ready(y_ready_a)
  );

  stoch_signed_decode #(.NUM_ELEMS(NB), .WINDOW_LOG2(WB)) dut_b (
    .CLK(clk), .nRST(n_rst), .start(start_b), .x_p(xp_b), .x_m(xm_b),
    .busy(busy_b), .y(y_b), .y_valid(y_valid_b), .y_ready(y_ready_b)
  );

  // Runs one full window on dut_a with the pp/pm patterns and checks the result.
  task automatic window_a(input bit from_hold, input string tag);
    int              e [NA];
    logic [NA*OA-1:0] ey;
    logic signed [OA-1:0] t;
    for (int i = 0; i < NA; i++) begin
      e[i] = 0;
      for (int k = 0; k < LA; k++) e[i] += int'(pp[k][i]) - int'(pm[k][i]);
      t = OA'(e[i]);
      ey[i*OA +: OA] = t;
    end
    start_a = 1'b1;
    y_ready_a = from_hold;
    @(posedge clk); #1;
    start_a = 1'b0;
    y_ready_a = 1'b0;
    n_vec++;
    if (busy_a !== 1'b1 || y_valid_a !== 1'b0) begin
      n_miss++;
      $display("FAIL %s_launch: busy=%b y_valid=%b, want busy=1 y_valid=0", tag, busy_a, y_valid_a);
    end
    for (int k = 0; k < LA; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      xp_a = pp[k];
      xm_a = pm[k];
      if (k == LA - 1) begin
        n_vec++;
        if (y_valid_a !== 1'b0 || busy_a !== 1'b1) begin
          n_miss++;
          $display("FAIL %s_early: y_valid=%b busy=%b before window end, want 0/1", tag, y_valid_a, busy_a);
        end
      end
    end
    @(posedge clk); #1;
    xp_a = NA'($urandom);
    xm_a = NA'($urandom);
    n_vec++;
    if (y_valid_a !== 1'b1 || busy_a !== 1'b0 || y_a !== ey) begin
      n_miss++;
      $display("FAIL %s_result: y=%h y_valid=%b busy=%b, want y=%h y_valid=1 busy=0",
               tag, y_a, y_valid_a, busy_a, ey);
    end
  endtask

  task automatic handshake_a(input string tag);
    logic [NA*OA-1:0] held;
    held = y_a;
    y_ready_a = 1'b1;
    @(posedge clk); #1;
    y_ready_a = 1'b0;
    n_vec++;
    if (y_valid_a !== 1'b0 || busy_a !== 1'b0 || y_a !== held) begin
      n_miss++;
      $display("FAIL %s_handshake: y_valid=%b busy=%b y=%h, want 0/0 y=%h", tag, y_valid_a, busy_a, y_a, held);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (y_a !== '0 || y_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_a: y=%h y_valid=%b busy=%b, want all 0", y_a, y_valid_a, busy_a);
    end
    n_vec++;
    if (y_b !== '0 || y_valid_b !== 1'b0 || busy_b !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_b: y=%h y_valid=%b busy=%b, want all 0", y_b, y_valid_b, busy_b);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_positive();
    for (int k = 0; k < LA; k++) begin
      pp[k] = 4'b0001;
      pm[k] = 4'b0000;
    end
    window_a(1'b0, "positive");
    handshake_a("positive");
  endtask

  task automatic test_mixed();
    for (int k = 0; k < LA; k++) begin
      pp[k] = {(k % 2 == 0), 1'b1, 2'b00};
      pm[k] = 4'b0110;
    end
    window_a(1'b0, "mixed");
  endtask

  task automatic test_hold_stall();
    logic [NA*OA-1:0] held;
    held = y_a;
    for (int c = 0; c < 10; c++) begin
      y_ready_a = 1'b0;
      start_a = (c == 4 || c == 5);
      @(posedge clk); #1;
      n_vec++;
      if (y_valid_a !== 1'b1 || busy_a !== 1'b0 || y_a !== held) begin
        n_miss++;
        $display("FAIL hold_stall c=%0d: y_valid=%b busy=%b y=%h, want 1/0 y=%h", c, y_valid_a, busy_a, y_a, held);
      end
    end
    start_a = 1'b0;
    handshake_a("hold_release");
    repeat (3) begin
      @(posedge clk); #1;
      n_vec++;
      if (y_valid_a !== 1'b0 || busy_a !== 1'b0) begin
        n_miss++;
        $display("FAIL hold_idle: y_valid=%b busy=%b, want 0/0", y_valid_a, busy_a);
      end
    end
  endtask

  task automatic test_back_to_back();
    handshake_a("pre_b2b");
    for (int k = 0; k < LA; k++) begin
      pp[k] = 4'b0001;
      pm[k] = 4'b0000;
    end
    window_a(1'b0, "b2b_first");
    for (int k = 0; k < LA; k++) begin
      pp[k] = (k % 5 == 0) ? 4'b0001 : 4'b0000;
      pm[k] = 4'b0000;
    end
    window_a(1'b1, "b2b_second");
  endtask

  task automatic test_reset_mid();
    start_a = 1'b1;
    y_ready_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    y_ready_a = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      xp_a = '1;
      xm_a = '0;
    end
    #2;
    n_rst = 1'b0;
    #1;
    n_vec++;
    if (y_a !== '0 || y_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_mid_async: y=%h y_valid=%b busy=%b, want all 0", y_a, y_valid_a, busy_a);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      n_vec++;
      if (y_a !== '0 || y_valid_a !== 1'b0 || busy_a !== 1'b0) begin
        n_miss++;
        $display("FAIL reset_mid_idle: y=%h y_valid=%b busy=%b, want all 0", y_a, y_valid_a, busy_a);
      end
    end
    for (int k = 0; k < LA; k++) begin
      pp[k] = 4'b1001;
      pm[k] = (k < 3) ? 4'b0001 : 4'b0000;
    end
    window_a(1'b0, "after_reset");
  endtask

  // Full-size instance: random streams, random stalls, random back-to-back launches.
  task automatic test_random_windows();
    int                   eb [NB];
    logic [NB*OB-1:0]     ey, held;
    logic signed [OB-1:0] t;
    int                   mode;
    mode = 0;
    for (int w = 0; w < 100; w++) begin
      start_b = 1'b1;
      y_ready_b = (mode == 1);
      @(posedge clk); #1;
      start_b = 1'b0;
      y_ready_b = 1'b0;
      n_vec++;
      if (busy_b !== 1'b1 || y_valid_b !== 1'b0) begin
        n_miss++;
        $display("FAIL rand_launch w=%0d: busy=%b y_valid=%b, want 1/0", w, busy_b, y_valid_b);
      end
      for (int i = 0; i < NB; i++) eb[i] = 0;
      for (int k = 0; k < LB; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        xp_b = NB'($urandom);
        xm_b = NB'($urandom);
        for (int i = 0; i < NB; i++) eb[i] += int'(xp_b[i]) - int'(xm_b[i]);
        if (k == LB - 1) begin
          n_vec++;
          if (y_valid_b !== 1'b0) begin
            n_miss++;
            $display("FAIL rand_early w=%0d: y_valid=%b, want 0", w, y_valid_b);
          end
        end
      end
      for (int i = 0; i < NB; i++) begin
        t = OB'(eb[i]);
        ey[i*OB +: OB] = t;
      end
      @(posedge clk); #1;
      xp_b = NB'($urandom);
      xm_b = NB'($urandom);
      n_vec++;
      if (y_valid_b !== 1'b1 || busy_b !== 1'b0 || y_b !== ey) begin
        n_miss++;
        $display("FAIL rand_result w=%0d: y=%h y_valid=%b, want y=%h y_valid=1", w, y_b, y_valid_b, ey);
      end
      held = y_b;
      repeat ($urandom_range(0, 4)) begin
        start_b = 1'($urandom_range(0, 1));
        y_ready_b = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (y_valid_b !== 1'b1 || busy_b !== 1'b0 || y_b !== held) begin
          n_miss++;
          $display("FAIL rand_stall w=%0d: y_valid=%b busy=%b, y changed=%b", w, y_valid_b, busy_b, y_b !== held);
        end
      end
      start_b = 1'b0;
      mode = $urandom_range(0, 1);
      if (mode == 0) begin
        y_ready_b = 1'b1;
        @(posedge clk); #1;
        y_ready_b = 1'b0;
        n_vec++;
        if (y_valid_b !== 1'b0 || busy_b !== 1'b0 || y_b !== held) begin
          n_miss++;
          $display("FAIL rand_handshake w=%0d: y_valid=%b busy=%b, y changed=%b", w, y_valid_b, busy_b, y_b !== held);
        end
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_mixed();
    test_hold_stall();
    test_back_to_back();
    test_reset_mid();
    test_random_windows();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
